uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- UART boot-loader that drives the programmer port set consumed by instruction fetch and data memory: upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o.
- Deserialises an 8N1 byte stream, parses section headers, packs little-endian bytes into 32-bit words and emits one single-cycle write per word.
- upg_adr_o[14] selects program (0) or data (1); upg_done_o releases the CPU.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- CNT_W, 16, width of the per-section word-count field.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- rx  input  1  UART serial input, idle high, asynchronous to clk.
- start  input  1  single-cycle pulse: clear done, re-arm parser.
- upg_wen_o  output  1  one-cycle write strobe.
- upg_adr_o  output  15  [14] region, [13:0] word index.
- upg_dat_o  output  32  assembled word.
- upg_done_o  output  1  load complete; stays high until start or reset.
- upg_err_o  output  1  sticky error flag (framing/header/checksum).

Behaviour:
- Reset values:
  - upg_wen_o=0, upg_adr_o=0, upg_dat_o=0.
  - upg_done_o=0, upg_err_o=0.
  - Parser state HDR_REGION; RX FSM IDLE.
- Reset asserted mid-byte or mid-section: all state is discarded and the partial word is never written.
- rx passes through a 2-flop synchroniser before use.
- RX FSM:
  - IDLE: wait for a low level.
  - START: recheck at CLKS_PER_BIT/2. If high, treat as a glitch and return to IDLE.
  - DATA: 8 bits sampled at bit centres, LSB first.
  - STOP: sample at the stop-bit centre. High: emit a byte_valid pulse for 1 cycle. Low: drop the byte, set err, return to IDLE.
- Parser FSM, advanced once per byte_valid:
  - HDR_REGION:
    - 0x00 → program region, adr[14]=0.
    - 0x01 → data region, adr[14]=1.
    - 0xFF → DONE.
    - Any other value → set err, stay in HDR_REGION.
  - CNT_LO → CNT_HI: word count N, little-endian.
    - N=0 → go straight to section end (HDR_REGION, or CHK if enabled).
  - DATA: byte k of a word goes to bits [8k+7:8k].
    - On the 4th byte, upg_dat_o/upg_adr_o update and upg_wen_o pulses 1 cycle later, with address and data stable in that cycle.
    - Word index starts at 0 each section, increments after each write, wraps modulo 2^14.
    - After N words the section ends.
  - DONE: upg_done_o=1, further bytes are ignored, upg_wen_o never asserts.
- start pulse, any state:
  - Parser goes to HDR_REGION; upg_done_o and upg_err_o clear next cycle.
  - The RX FSM is not reset, so an in-flight byte still completes and is parsed.
- start and byte_valid in the same cycle: start wins and the byte is discarded.
- Latency: upg_wen_o asserts exactly 1 clk after the stop-bit sample of the 4th byte.
- err never blocks progress except in checksum-failure DONE (see below).

Optional Feature:
- Macro UPG_CHECKSUM_EN.
- Defined:
  - After each section's data, parser enters CHK and takes one byte: the XOR of every data byte in the section (0x00 when N=0).
  - Match → HDR_REGION.
  - Mismatch → upg_err_o=1 and parser enters DONE with upg_done_o held 0; only start or reset recovers.
- Undefined: no CHK state and no checksum byte; the section ends directly after the last word.

Test Plan:
- Reset, then stream 00 01 00 78 56 34 12 FF → one wen pulse: adr=0x0000, dat=0x12345678; then done=1, err=0.
- Stream 01 02 00 + bytes 01..08 + FF → writes adr=0x4000 dat=0x04030201, adr=0x4001 dat=0x08070605; done=1.
- Byte with stop bit forced low during the data phase → byte dropped, err=1, no wen. A later complete, well-formed word is still written.
- Header 0x05, then 00 00 00 FF → err=1, no writes, done=1. Pulse start → done=0, err=0.
- Reset asserted after 2 data bytes, then a full stream 00 01 00 AA BB CC DD FF → single write dat=0xDDCCBBAA at adr 0.
- With UPG_CHECKSUM_EN: 00 01 00 11 22 33 44 44 FF → write, then done=1. Checksum byte 0x45 instead → err=1, done=0.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART (8N1) boot-loader that drives the programmer port.
// It parses sections of the form <region> <count lo> <count hi> <4*N data bytes>,
// packs the data little-endian into 32-bit words and issues one write per word.
// A 0xFF header ends the load and raises upg_done_o.
// Optional feature macro: UPG_CHECKSUM_EN. When it is defined, each section
// carries one trailing XOR checksum byte.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        start,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        HDR_REGION, CNT_LO, CNT_HI, DATA_BYTE, DONE
`ifdef UPG_CHECKSUM_EN
        , CHK
`endif
    } p_state_t;

    // State that follows the last word of a section (or a zero count).
    localparam p_state_t SEC_END =
`ifdef UPG_CHECKSUM_EN
        CHK;
`else
        HDR_REGION;
`endif

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            byte_valid, frame_err;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
        end
    end

    // Receiver next state: find start edge, confirm at half bit, sample at bit centres.
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rx_sync_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else                   bit_idx_d  = bit_idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) byte_valid = 1'b1;
                    else           frame_err  = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- parser ----------------
    p_state_t         p_state_q, p_state_d;
    logic             region_q, region_d;
    logic [7:0]       cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      word_q, word_d;
    logic [13:0]      idx_q, idx_d;
    logic [14:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             wen_pend_q, wen_pend_d;
    logic             wen_q, wen_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    // Parser state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_state_q    <= HDR_REGION;
            region_q     <= 1'b0;
            cnt_lo_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            wen_pend_q   <= 1'b0;
            wen_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            p_state_q    <= p_state_d;
            region_q     <= region_d;
            cnt_lo_q     <= cnt_lo_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            wen_pend_q   <= wen_pend_d;
            wen_q        <= wen_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef UPG_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    // Parser next state: one step per received byte; start overrides everything.
    // Address/data are registered with the 4th byte; the strobe follows a cycle
    // later so both are already stable while it is high.
    always_comb begin
        p_state_d    = p_state_q;
        region_d     = region_q;
        cnt_lo_d     = cnt_lo_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        idx_d        = idx_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        wen_pend_d   = 1'b0;
        wen_d        = wen_pend_q;
        done_d       = done_q;
        err_d        = err_q | frame_err;
`ifdef UPG_CHECKSUM_EN
        chk_d        = chk_q;
`endif
        if (start) begin
            p_state_d = HDR_REGION;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end else if (byte_valid) begin
            case (p_state_q)
                HDR_REGION: begin
                    idx_d      = '0;
                    byte_idx_d = '0;
`ifdef UPG_CHECKSUM_EN
                    chk_d      = '0;
`endif
                    case (shreg_q)
                        8'h00: begin region_d = 1'b0; p_state_d = CNT_LO; end
                        8'h01: begin region_d = 1'b1; p_state_d = CNT_LO; end
                        8'hFF: begin done_d   = 1'b1; p_state_d = DONE;   end
                        default: err_d = 1'b1;
                    endcase
                end
                CNT_LO: begin
                    cnt_lo_d  = shreg_q;
                    p_state_d = CNT_HI;
                end
                CNT_HI: begin
                    words_left_d = CNT_W'({shreg_q, cnt_lo_q});
                    p_state_d    = (words_left_d == '0) ? SEC_END : DATA_BYTE;
                end
                DATA_BYTE: begin
`ifdef UPG_CHECKSUM_EN
                    chk_d = chk_q ^ shreg_q;
`endif
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = shreg_q;
                        2'd1: word_d[15:8]  = shreg_q;
                        2'd2: word_d[23:16] = shreg_q;
                        default: begin
                            dat_d        = {shreg_q, word_q};
                            adr_d        = {region_q, idx_q};
                            idx_d        = idx_q + 14'd1;
                            wen_pend_d   = 1'b1;
                            words_left_d = words_left_q - CNT_W'(1);
                            if (words_left_q == CNT_W'(1)) p_state_d = SEC_END;
                        end
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                end
`ifdef UPG_CHECKSUM_EN
                CHK: begin
                    if (shreg_q == chk_q) begin
                        p_state_d = HDR_REGION;
                    end else begin
                        err_d     = 1'b1;
                        p_state_d = DONE;
                    end
                end
`endif
                DONE: ;
                default: p_state_d = HDR_REGION;
            endcase
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed scenarios plus random
// section streams compared against a byte-list reference model.
module tb_uart_prog_loader;
    localparam int CPB    = 16;
    localparam int BIT_NS = CPB * 10;

    typedef logic [7:0] u8;

    logic        clk = 1'b0;
    logic        rst, rx, start;
    logic        upg_wen_o, upg_done_o, upg_err_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    int checks   = 0;
    int failures = 0;

    logic [14:0] got_adr[$];
    logic [31:0] got_dat[$];
    logic [14:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic        exp_done, exp_err;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .start(start),
        .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
        .upg_done_o(upg_done_o), .upg_err_o(upg_err_o)
    );

    always #5 clk = ~clk;

    // Write monitor: every cycle with the strobe high is one write.
    always @(negedge clk) begin
        if (rst && upg_wen_o) begin
            got_adr.push_back(upg_adr_o);
            got_dat.push_back(upg_dat_o);
        end
    end

    task automatic send_byte(input u8 b, input logic stop_ok);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop_ok;
        #(BIT_NS);
        rx = 1'b1;
        #(BIT_NS);
    endtask

    task automatic send_stream(input u8 s[$]);
        foreach (s[i]) send_byte(s[i], 1'b1);
        #(BIT_NS);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_got();
        got_adr.delete();
        got_dat.delete();
    endtask

    function automatic u8 xsum(input u8 s[$]);
        u8 x = 8'h00;
        foreach (s[i]) x ^= s[i];
        return x;
    endfunction

    // Reference model: walks the byte list section by section.
    task automatic run_model(input u8 s[$]);
        int i = 0;
        exp_adr.delete();
        exp_dat.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (i < s.size()) begin
            u8  h = s[i];
            int n;
            u8  x = 8'h00;
            i++;
            if (h == 8'hFF) begin exp_done = 1'b1; break; end
            if (h > 8'h01) begin exp_err = 1'b1; continue; end
            n = int'(s[i]) + 256 * int'(s[i+1]);
            i += 2;
            for (int w = 0; w < n; w++) begin
                logic [31:0] word = 0;
                for (int k = 0; k < 4; k++) begin
                    word = word + (32'(s[i+k]) << (8 * k));
                    x ^= s[i+k];
                end
                i += 4;
                exp_adr.push_back(15'(h[0] * 16384 + (w % 16384)));
                exp_dat.push_back(word);
            end
`ifdef UPG_CHECKSUM_EN
            if (s[i] != x) begin exp_err = 1'b1; i++; break; end
            i++;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1; start = 1'b0;
        #23;
        checks += 5;
        if (upg_wen_o !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", upg_wen_o); end
        if (upg_adr_o !== 15'h0) begin failures++; $display("FAIL reset_adr got=%h exp=0", upg_adr_o); end
        if (upg_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", upg_dat_o); end
        if (upg_done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", upg_done_o); end
        if (upg_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", upg_err_o); end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        u8 s[$] = '{8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef UPG_CHECKSUM_EN
        s.push_back(8'h08);
`endif
        s.push_back(8'hFF);
        clear_got();
        send_stream(s);
        checks += 5;
        if (got_adr.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_adr.size()); end
        if (got_adr[0] !== 15'h0000) begin failures++; $display("FAIL single_adr got=%h exp=0000", got_adr[0]); end
        if (got_dat[0] !== 32'h12345678) begin failures++; $display("FAIL single_dat got=%h exp=12345678", got_dat[0]); end
        if (upg_done_o !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", upg_done_o); end
        if (upg_err_o !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", upg_err_o); end
    endtask

    task automatic test_data_region();
        u8 s[$] = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef UPG_CHECKSUM_EN
        s.push_back(8'h08);
`endif
        s.push_back(8'hFF);
        pulse_start();
        checks += 1;
        if (upg_done_o !== 1'b0) begin failures++; $display("FAIL start_clears_done got=%b exp=0", upg_done_o); end
        clear_got();
        send_stream(s);
        checks += 6;
        if (got_adr.size() != 2) begin failures++; $display("FAIL data_count got=%0d exp=2", got_adr.size()); end
        if (got_adr[0] !== 15'h4000) begin failures++; $display("FAIL data_adr0 got=%h exp=4000", got_adr[0]); end
        if (got_dat[0] !== 32'h04030201) begin failures++; $display("FAIL data_dat0 got=%h exp=04030201", got_dat[0]); end
        if (got_adr[1] !== 15'h4001) begin failures++; $display("FAIL data_adr1 got=%h exp=4001", got_adr[1]); end
        if (got_dat[1] !== 32'h08070605) begin failures++; $display("FAIL data_dat1 got=%h exp=08070605", got_dat[1]); end
        if (upg_done_o !== 1'b1) begin failures++; $display("FAIL data_done got=%b exp=1", upg_done_o); end
    endtask

    task automatic test_framing();
        u8 s[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UPG_CHECKSUM_EN
        s.push_back(8'h44);
`endif
        s.push_back(8'hFF);
        pulse_start();
        clear_got();
        send_stream('{8'h00, 8'h01, 8'h00});
        send_byte(8'h5A, 1'b0);
        #(BIT_NS);
        checks += 2;
        if (upg_err_o !== 1'b1) begin failures++; $display("FAIL frame_err got=%b exp=1", upg_err_o); end
        if (got_adr.size() != 0) begin failures++; $display("FAIL frame_nowen got=%0d exp=0", got_adr.size()); end
        send_stream(s);
        checks += 4;
        if (got_adr.size() != 1) begin failures++; $display("FAIL frame_count got=%0d exp=1", got_adr.size()); end
        if (got_dat[0] !== 32'h44332211) begin failures++; $display("FAIL frame_dat got=%h exp=44332211", got_dat[0]); end
        if (upg_done_o !== 1'b1) begin failures++; $display("FAIL frame_done got=%b exp=1", upg_done_o); end
        if (upg_err_o !== 1'b1) begin failures++; $display("FAIL frame_err_sticky got=%b exp=1", upg_err_o); end
    endtask

    task automatic test_bad_header();
        u8 s[$] = '{8'h00, 8'h00, 8'h00};
`ifdef UPG_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        s.push_back(8'hFF);
        pulse_start();
        checks += 1;
        if (upg_err_o !== 1'b0) begin failures++; $display("FAIL start_clears_err got=%b exp=0", upg_err_o); end
        clear_got();
        send_stream('{8'h05});
        checks += 1;
        if (upg_err_o !== 1'b1) begin failures++; $display("FAIL hdr_err got=%b exp=1", upg_err_o); end
        send_stream(s);
        checks += 3;
        if (got_adr.size() != 0) begin failures++; $display("FAIL hdr_nowen got=%0d exp=0", got_adr.size()); end
        if (upg_done_o !== 1'b1) begin failures++; $display("FAIL hdr_done got=%b exp=1", upg_done_o); end
        if (upg_err_o !== 1'b1) begin failures++; $display("FAIL hdr_err_sticky got=%b exp=1", upg_err_o); end
        pulse_start();
        checks += 2;
        if (upg_done_o !== 1'b0) begin failures++; $display("FAIL hdr_start_done got=%b exp=0", upg_done_o); end
        if (upg_err_o !== 1'b0) begin failures++; $display("FAIL hdr_start_err got=%b exp=0", upg_err_o); end
    endtask

    task automatic test_reset_mid();
        u8 s[$] = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef UPG_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        s.push_back(8'hFF);
        clear_got();
        send_stream('{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB});
        @(negedge clk) rst = 1'b0;
        #30;
        checks += 1;
        if (upg_dat_o !== 32'h0) begin failures++; $display("FAIL rstmid_dat got=%h exp=0", upg_dat_o); end
        @(negedge clk) rst = 1'b1;
        #(BIT_NS);
        send_stream(s);
        checks += 4;
        if (got_adr.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", got_adr.size()); end
        if (got_adr[0] !== 15'h0) begin failures++; $display("FAIL rstmid_adr got=%h exp=0000", got_adr[0]); end
        if (got_dat[0] !== 32'hDDCCBBAA) begin failures++; $display("FAIL rstmid_dat got=%h exp=DDCCBBAA", got_dat[0]); end
        if (upg_done_o !== 1'b1) begin failures++; $display("FAIL rstmid_done got=%b exp=1", upg_done_o); end
    endtask

`ifdef UPG_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        clear_got();
        send_stream('{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45, 8'hFF});
        checks += 4;
        if (got_adr.size() != 1) begin failures++; $display("FAIL chk_count got=%0d exp=1", got_adr.size()); end
        if (got_dat[0] !== 32'h44332211) begin failures++; $display("FAIL chk_dat got=%h exp=44332211", got_dat[0]); end
        if (upg_err_o !== 1'b1) begin failures++; $display("FAIL chk_err got=%b exp=1", upg_err_o); end
        if (upg_done_o !== 1'b0) begin failures++; $display("FAIL chk_done got=%b exp=0", upg_done_o); end
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            u8  s[$];
            int nsec = $urandom_range(1, 2);
            for (int sec = 0; sec < nsec; sec++) begin
                u8  d[$];
                int n = $urandom_range(0, 3);
                s.push_back(u8'($urandom_range(0, 1)));
                s.push_back(u8'(n));
                s.push_back(8'h00);
                for (int k = 0; k < 4 * n; k++) d.push_back(u8'($urandom));
                foreach (d[k]) s.push_back(d[k]);
`ifdef UPG_CHECKSUM_EN
                s.push_back(xsum(d));
`endif
            end
            s.push_back(8'hFF);
            run_model(s);
            pulse_start();
            clear_got();
            send_stream(s);
            checks += 3;
            if (got_adr.size() != exp_adr.size()) begin
                failures++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, got_adr.size(), exp_adr.size());
            end
            if (upg_done_o !== exp_done) begin failures++; $display("FAIL rand_done it=%0d got=%b exp=%b", it, upg_done_o, exp_done); end
            if (upg_err_o !== exp_err) begin failures++; $display("FAIL rand_err it=%0d got=%b exp=%b", it, upg_err_o, exp_err); end
            foreach (exp_adr[k]) begin
                checks += 1;
                if (got_adr[k] !== exp_adr[k] || got_dat[k] !== exp_dat[k]) begin
                    failures++;
                    $display("FAIL rand_write it=%0d k=%0d got=%h/%h exp=%h/%h", it, k, got_adr[k], got_dat[k], exp_adr[k], exp_dat[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_data_region();
        test_framing();
        test_bad_header();
        test_reset_mid();
`ifdef UPG_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
